// File: rtl/exe_divider.sv
// Iterative 32-bit restoring divider for the EXE stage: DIV/DIVU, 33-cycle latency, result {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in 2 cycles via the ZERO state.
module exe_divider (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        flush,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        stallreq_div,
    output logic        div_ready,
    output logic [63:0] div_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        ZERO = 2'd1,
`endif
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] partRem_q, partRem_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] divisorMag_q, divisorMag_d;
    logic [31:0] origDividend_q, origDividend_d;
    logic        negQuo_q, negQuo_d;
    logic        negRem_q, negRem_d;
    logic        divZero_q, divZero_d;
    logic [63:0] result_q, result_d;

    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [32:0] shifted;
    logic        stepGe;
    logic [31:0] stepRem;
    logic [31:0] stepQuo;
    logic [31:0] fixRem;
    logic [31:0] fixQuo;
    logic [63:0] zeroResult;

    // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
    always_comb begin
        dividendMag = (div_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
        divisorMag  = (div_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
        shifted     = {partRem_q, quotient_q[31]};
        stepGe      = (shifted >= {1'b0, divisorMag_q});
        stepRem     = stepGe ? (shifted[31:0] - divisorMag_q) : shifted[31:0];
        stepQuo     = {quotient_q[30:0], stepGe};
        fixQuo      = negQuo_q ? (32'd0 - stepQuo) : stepQuo;
        fixRem      = negRem_q ? (32'd0 - stepRem) : stepRem;
        zeroResult  = {origDividend_q, 32'hFFFF_FFFF};
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        partRem_d      = partRem_q;
        quotient_d     = quotient_q;
        divisorMag_d   = divisorMag_q;
        origDividend_d = origDividend_q;
        negQuo_d       = negQuo_q;
        negRem_d       = negRem_q;
        divZero_d      = divZero_q;
        result_d       = result_q;

        case (state_q)
            IDLE: begin
                if (div_start && !flush) begin
                    count_d        = 6'd0;
                    partRem_d      = 32'd0;
                    quotient_d     = dividendMag;
                    divisorMag_d   = divisorMag;
                    origDividend_d = dividend;
                    negQuo_d       = div_signed && (dividend[31] ^ divisor[31]);
                    negRem_d       = div_signed && dividend[31];
                    divZero_d      = (divisor == 32'd0);
`ifdef DIV_ZERO_FAST_EN
                    state_d        = (divisor == 32'd0) ? ZERO : BUSY;
`else
                    state_d        = BUSY;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                result_d = zeroResult;
                state_d  = DONE;
            end
`endif
            BUSY: begin
                partRem_d  = stepRem;
                quotient_d = stepQuo;
                count_d    = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    result_d = divZero_q ? zeroResult : {fixRem, fixQuo};
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons the instruction, including one that would complete on this edge.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q        <= IDLE;
            count_q        <= 6'd0;
            partRem_q      <= 32'd0;
            quotient_q     <= 32'd0;
            divisorMag_q   <= 32'd0;
            origDividend_q <= 32'd0;
            negQuo_q       <= 1'b0;
            negRem_q       <= 1'b0;
            divZero_q      <= 1'b0;
            result_q       <= 64'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            partRem_q      <= partRem_d;
            quotient_q     <= quotient_d;
            divisorMag_q   <= divisorMag_d;
            origDividend_q <= origDividend_d;
            negQuo_q       <= negQuo_d;
            negRem_q       <= negRem_d;
            divZero_q      <= divZero_d;
            result_q       <= result_d;
        end
    end

    // Stall drops in DONE so the divide instruction leaves EXE in the same cycle its result is valid.
    always_comb begin
        stallreq_div = 1'b0;
        case (state_q)
            IDLE:    stallreq_div = div_start && !flush;
`ifdef DIV_ZERO_FAST_EN
            ZERO:    stallreq_div = 1'b1;
`endif
            BUSY:    stallreq_div = 1'b1;
            default: stallreq_div = 1'b0;
        endcase
        if (cpu_rst) begin
            stallreq_div = 1'b0;
        end
        div_ready  = (state_q == DONE) && !flush && !cpu_rst;
        div_result = result_q;
    end

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: directed cases, flush/reset aborts, back-to-back and random divides
// checked against an arithmetic reference model.
module tb_exe_divider;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        flush;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stallreq_div;
    logic        div_ready;
    logic [63:0] div_result;

    int errors = 0;
    int checks = 0;

    exe_divider dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .flush       (flush),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .stallreq_div(stallreq_div),
        .div_ready   (div_ready),
        .div_result  (div_result)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    // Reference: plain integer division, truncating toward zero, remainder follows the dividend.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    function automatic int refLatency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 2 : 33;
`else
        if (b == 32'd0) return 33;
        return 33;
`endif
    endfunction

    // Presents a divide in the current cycle (cycle 0) and waits for div_ready; operands are scrambled
    // after capture unless hold is set, in which case div_start and the operands stay asserted.
    task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output logic [63:0] res, output int lat, output bit stallOk);
        stallOk    = 1'b1;
        lat        = -1;
        res        = 64'd0;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        #1;
        if (stallreq_div !== 1'b1) stallOk = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge cpu_clk_50M);
            #1;
            if (!hold) begin
                div_start  = 1'b0;
                dividend   = $urandom;
                divisor    = $urandom;
                div_signed = 1'($urandom);
            end
            #1;
            if (div_ready === 1'b1) begin
                lat = n;
                res = div_result;
                if (stallreq_div !== 1'b0) stallOk = 1'b0;
                break;
            end
            if (stallreq_div !== 1'b1) stallOk = 1'b0;
        end
    endtask

    task automatic test_reset;
        cpu_rst    = 1'b1;
        flush      = 1'b0;
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        repeat (3) @(posedge cpu_clk_50M);
        #1;
        checks++;
        if (stallreq_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_div);
        end
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", div_ready);
        end
        checks++;
        if (div_result !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_result: got %h expected 0", div_result);
        end
        div_start = 1'b0;
        cpu_rst   = 1'b0;
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic test_directed;
        logic [31:0] as [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF00};
        logic [31:0] bs [5] = '{32'd7,   32'd2,         32'hFFFF_FFFF, 32'd0,         32'd0};
        logic        ss [5] = '{1'b0,    1'b1,          1'b1,          1'b0,          1'b1};
        logic [63:0] exps [5] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                                  {32'h1234_5678, 32'hFFFF_FFFF}, {32'hFFFF_FF00, 32'hFFFF_FFFF}};
        logic [63:0] res;
        int          lat;
        bit          stallOk;
        for (int i = 0; i < 5; i++) begin
            runDiv(ss[i], as[i], bs[i], 1'b0, res, lat, stallOk);
            checks++;
            if (res !== exps[i]) begin
                errors++;
                $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, exps[i]);
            end
            checks++;
            if (lat != refLatency(bs[i])) begin
                errors++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, refLatency(bs[i]));
            end
            checks++;
            if (!stallOk) begin
                errors++;
                $display("[TB] FAIL directed_stall[%0d]: stall profile wrong, expected 1 before ready and 0 at ready", i);
            end
            @(posedge cpu_clk_50M);
            #1;
        end
    endtask

    task automatic test_flush;
        logic [63:0] res;
        int          lat;
        bit          stallOk;
        div_signed = 1'b0;
        dividend   = 32'd50;
        divisor    = 32'd5;
        div_start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge cpu_clk_50M);
            #1;
            div_start = 1'b0;
        end
        flush = 1'b1;
        @(posedge cpu_clk_50M);
        #1;
        flush = 1'b0;
        #1;
        checks++;
        if (stallreq_div !== 1'b0 || div_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle: got stall=%b ready=%b expected 0 0", stallreq_div, div_ready);
        end
        @(posedge cpu_clk_50M);
        #1;
        runDiv(1'b0, 32'd9, 32'd3, 1'b0, res, lat, stallOk);
        checks++;
        if (res !== {32'd0, 32'd3} || lat != 33) begin
            errors++;
            $display("[TB] FAIL flush_next: got %h at latency %0d expected %h at 33", res, lat, {32'd0, 32'd3});
        end
    endtask

    task automatic test_flush_at_completion;
        logic [63:0] held;
        held       = div_result;
        div_signed = 1'b0;
        dividend   = 32'd21;
        divisor    = 32'd4;
        div_start  = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(posedge cpu_clk_50M);
            #1;
            div_start = 1'b0;
        end
        flush = 1'b1;
        @(posedge cpu_clk_50M);
        #1;
        flush = 1'b0;
        #1;
        checks++;
        if (div_ready !== 1'b0 || stallreq_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_done_ready: got ready=%b stall=%b expected 0 0", div_ready, stallreq_div);
        end
        checks++;
        if (div_result !== held) begin
            errors++;
            $display("[TB] FAIL flush_done_result: got %h expected held %h", div_result, held);
        end
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic test_reset_abort;
        logic [63:0] res;
        int          lat;
        bit          stallOk;
        div_signed = 1'b0;
        dividend   = 32'd50;
        divisor    = 32'd5;
        div_start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge cpu_clk_50M);
            #1;
            div_start = 1'b0;
        end
        cpu_rst = 1'b1;
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst = 1'b0;
        #1;
        checks++;
        if (div_ready !== 1'b0 || stallreq_div !== 1'b0 || div_result !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_abort: got ready=%b stall=%b result=%h expected all 0",
                     div_ready, stallreq_div, div_result);
        end
        runDiv(1'b1, 32'hFFFF_FFEC, 32'd6, 1'b0, res, lat, stallOk);
        checks++;
        if (res !== refDiv(1'b1, 32'hFFFF_FFEC, 32'd6) || lat != 33) begin
            errors++;
            $display("[TB] FAIL reset_recover: got %h at latency %0d expected %h at 33",
                     res, lat, refDiv(1'b1, 32'hFFFF_FFEC, 32'd6));
        end
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] res;
        int          lat;
        bit          stallOk;
        runDiv(1'b0, 32'd1000, 32'd33, 1'b1, res, lat, stallOk);
        checks++;
        if (res !== refDiv(1'b0, 32'd1000, 32'd33) || lat != 33) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %h at latency %0d expected %h at 33",
                     res, lat, refDiv(1'b0, 32'd1000, 32'd33));
        end
        @(posedge cpu_clk_50M);
        #1;
        runDiv(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0, res, lat, stallOk);
        checks++;
        if (res !== refDiv(1'b1, 32'hFFFF_FC18, 32'd7) || lat != 33) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h at latency %0d expected %h at 33",
                     res, lat, refDiv(1'b1, 32'hFFFF_FC18, 32'd7));
        end
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic test_random;
        logic [63:0] res;
        int          lat;
        bit          stallOk;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            s = 1'($urandom);
            runDiv(s, a, b, 1'b0, res, lat, stallOk);
            checks++;
            if (res !== refDiv(s, a, b)) begin
                errors++;
                $display("[TB] FAIL random_result[%0d] s=%b %h/%h: got %h expected %h", i, s, a, b, res, refDiv(s, a, b));
            end
            checks++;
            if (lat != refLatency(b) || !stallOk) begin
                errors++;
                $display("[TB] FAIL random_timing[%0d]: got latency %0d stallOk=%b expected %0d 1",
                         i, lat, stallOk, refLatency(b));
            end
            @(posedge cpu_clk_50M);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_flush_at_completion();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/exe_divider.md
EXE_DIVIDER -- requirements
Module: exe_divider

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-high reset:
  - cpu_clk_50M  input  1  clock; all state updates on the rising edge.
  - cpu_rst  input  1  synchronous, active-high reset.
- REQ-002 The block SHALL have these data and control ports:
  - flush  input  1  exception flush; aborts the in-flight divide.
  - div_start  input  1  a DIV/DIVU sits in EXE and requests a divide.
  - div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
  - dividend  input  32  EXE source operand 1.
  - divisor  input  32  EXE source operand 2.
  - stallreq_div  output  1  stall request to the pipeline controller while a divide is in progress.
  - div_ready  output  1  one-cycle pulse: div_result is valid.
  - div_result  output  64  {remainder (to HI), quotient (to LO)}.

Function
- REQ-003 The block SHALL implement a four-state FSM: IDLE, ZERO, BUSY, DONE.
- REQ-004 IDLE: if div_start=1 and flush=0, the block SHALL capture operands and div_signed, then:
  - go to ZERO if divisor==0 (when DIV_ZERO_FAST_EN is defined);
  - otherwise go to BUSY with the iteration counter cleared.
- REQ-005 stallreq_div SHALL be combinationally 1 when:
  - state is IDLE with div_start=1 and flush=0; or
  - state is BUSY; or
  - state is ZERO.
  It SHALL be 0 in DONE, so the instruction advances in the ready cycle.
- REQ-006 BUSY SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes using a 6-bit counter, and SHALL move to DONE after exactly 32 steps.
- REQ-007 Signed mode:
  - operands SHALL be converted to magnitudes at capture;
  - the quotient SHALL be negated when the operand signs differ;
  - the remainder SHALL take the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
- REQ-008 For divisor==0 (both modes), the result SHALL be quotient 0xFFFFFFFF and remainder = captured dividend.
- REQ-009 ZERO SHALL load the REQ-008 result and go to DONE on the next edge.
- REQ-010 DONE SHALL:
  - assert div_ready=1 for exactly one cycle with div_result held;
  - return to IDLE unconditionally;
  - ignore div_start in that cycle (it still belongs to the completing instruction).
- REQ-011 Latency, start edge to div_ready:
  - nonzero divisor: 33 cycles;
  - zero divisor with DIV_ZERO_FAST_EN: 2 cycles.
- REQ-012 div_result SHALL hold its last value outside DONE. It SHALL be sampled only when div_ready=1.
- REQ-013 flush=1 in any state SHALL force IDLE on the next edge with no div_ready pulse. flush takes priority over div_start and completion in the same cycle.
- REQ-014 Operand inputs SHALL be ignored after capture; changes during BUSY SHALL NOT affect the result.

Reset
- REQ-015 cpu_rst=1 at a rising edge SHALL set the following, overriding flush and div_start, including mid-divide:
  - state = IDLE, counter = 0;
  - div_ready = 0;
  - div_result = 64'h0;
  - internal operand/partial-remainder registers = 0.
- REQ-016 During reset, stallreq_div SHALL be 0.

Configuration
- REQ-017 Macro DIV_ZERO_FAST_EN:
  - defined: a zero divisor SHALL take the IDLE->ZERO->DONE path (2-cycle latency);
  - undefined: the ZERO state SHALL be absent, zero divisors SHALL run the full 32-step BUSY path, and DONE SHALL still force the REQ-008 result.

Verification
- REQ-018 DIVU 100 / 7:
  - stallreq_div=1 for cycles 0-32;
  - div_ready at cycle 33;
  - div_result = {32'd2, 32'd14}.
- REQ-019 DIV 0xFFFFFFF9 (-7) / 2 -> div_result = {0xFFFFFFFF, 0xFFFFFFFD}.
- REQ-020 DIV 0x80000000 / 0xFFFFFFFF -> div_result = {0x00000000, 0x80000000}.
- REQ-021 DIVU 0x12345678 / 0 -> div_result = {0x12345678, 0xFFFFFFFF}:
  - with DIV_ZERO_FAST_EN: ready at cycle 2;
  - without: ready at cycle 33.
- REQ-022 Flush and reset abort:
  - start DIVU 50/5, assert flush at cycle 10 -> IDLE at cycle 11, no div_ready;
  - new DIVU 9/3 at cycle 12 -> {0, 3} at cycle 45;
  - repeat with cpu_rst at cycle 10 -> all outputs 0 at cycle 11.
- REQ-023 Back-to-back divides:
  - hold div_start=1 through DONE -> no restart in the DONE cycle;
  - a second divide presented in the following cycle starts normally.
